com_slink_rx_chsel: RTL and testbench
=====================================

// Module: com_slink_rx_chsel
// PURPOSE
//  Redundant-lane receive selector for the SLINK RX path. Sits between NUM_CH MACRX byte streams and LLCRX.
//  Tracks per-lane health (watchdog + frame errors) and picks one active lane.
//  Forwards only whole frames from the active lane; switches lanes only at frame boundaries.
//  Replaces single-lane hookup with an N-lane, fail-over capable receive front end.
// PARAMETERS
//  NUM_CH     2   number of redundant lanes (2..16); localparam CH_W = $clog2(NUM_CH), min 1
//  DATA_W     8   byte-stream data width
//  WD_W       16  watchdog counter/threshold width
//  RECOV_FRM  2   consecutive good frames required to declare a lane alive (1..15)
// PORTS
//  clk_125m     in   1              single clock
//  rst_125m     in   1              synchronous reset, active-high
//  wd_timer     in   WD_W           watchdog threshold in cycles; 0 = watchdog disabled
//  ch_en        in   NUM_CH         per-lane enable; 0 forces lane dead
//  rx_dval      in   NUM_CH         per-lane byte valid
//  rx_sop       in   NUM_CH         per-lane start of frame (qualified by rx_dval)
//  rx_eop       in   NUM_CH         per-lane end of frame (qualified by rx_dval)
//  rx_err       in   NUM_CH         per-lane frame error, sampled with rx_eop
//  rx_data      in   NUM_CH*DATA_W  lane i at [i*DATA_W +: DATA_W]
//  out_dval     out  1              forwarded byte valid
//  out_sop      out  1              forwarded start of frame
//  out_eop      out  1              forwarded end of frame
//  out_err      out  1              frame error/truncation, valid with out_eop
//  out_data     out  DATA_W         forwarded byte
//  active_ch    out  CH_W           index of selected lane
//  ch_alive     out  NUM_CH         per-lane health
//  all_dead     out  1              no lane alive / no lane selected
//  switch_pulse out  1              1-cycle pulse when active_ch changes
// BEHAVIOUR
//  Reset: all outputs 0 except all_dead=1; wd counters, good-frame counters 0; FSM=IDLE.
//   Reset mid-frame: no closing eop is emitted.
//  Good eop per lane: rx_dval&rx_eop&!rx_err.
//  Health, per lane i, every cycle:
//   - ch_en[i]=0: alive=0, wd_cnt=0, good_cnt=0.
//   - good eop: wd_cnt=0; good_cnt saturates at RECOV_FRM; alive=1 when good_cnt reaches RECOV_FRM.
//   - error eop (rx_err=1): good_cnt=0; alive=0.
//   - otherwise: wd_cnt+1, saturating. If wd_timer!=0 and wd_cnt+1==wd_timer: alive=0, good_cnt=0.
//   - Good eop in the same cycle as timeout: the eop wins and the lane stays alive.
//  Output: registered; 1-cycle latency from rx_* to out_*. Non-active lanes are dropped but still feed health.
//  FSM:
//   IDLE:
//    - any alive: active_ch = lowest alive index; switch_pulse; -> GAP.
//   GAP:
//    - active lane not alive, another alive: active_ch = lowest alive; switch_pulse; stay GAP.
//    - no lane alive: all_dead=1; -> IDLE.
//    - active rx_dval&rx_sop: forward byte with out_sop; -> FWD. If the same byte has eop, also out_eop; stay GAP.
//    - active bytes without sop: dropped. A lane is never joined mid-frame.
//   FWD:
//    - forward each active rx_dval byte.
//    - on eop: out_eop=1, out_err=rx_err; -> GAP.
//    - active lane drops alive, or new sop without prior eop: emit 1 cycle out_dval=1, out_eop=1, out_err=1, out_data=0; -> GAP.
//     The stray sop is not forwarded.
//  all_dead = (FSM==IDLE). out_* are 0 in any cycle that forwards nothing.
// CONFIGURATION
//  SLINK_RX_REVERT_EN defined:
//   - in GAP, if a lower-index lane than active_ch is alive, switch to it (switch_pulse).
//   - never switches in FWD.
//  Not defined: non-revertive; active_ch changes only when the active lane dies.
// TESTING
//  T1 NUM_CH=2, wd_timer=100, lane0 sends 2 good frames
//     -> after 2nd eop lane0 alive; active_ch=0; switch_pulse once; all_dead 1->0.
//  T2 lane0 forwards 5-byte frame AA..AE
//     -> out bytes AA..AE one cycle later; sop on AA; eop on AE; out_err=0.
//  T3 lane0 and lane1 alive, lane0 silent 100 cycles in GAP
//     -> ch_alive[0]=0 at cycle 100; active_ch=1 next cycle; switch_pulse.
//  T4 ch_en[0]=0 mid-frame after 3 bytes
//     -> next cycle single out_eop, out_err=1, out_data=0; active_ch->1; later lane0 bytes dropped.
//  T5 lane0 recovers with 2 good frames while active_ch=1
//     -> REVERT_EN: active_ch=0 at next GAP; without it: active_ch stays 1.
//  T6 rst_125m during FWD, plus eop/timeout collision at wd_cnt=99 with wd_timer=100
//     -> outputs 0 with no eop after reset; collision leaves lane alive with wd_cnt=0.

Source files
------------

// File: rtl/com_slink_rx_chsel.sv
// com_slink_rx_chsel
//   Redundant-lane receive selector for the SLINK RX path. It watches
//   NUM_CH MACRX byte streams and tracks the health of each lane from its
//   watchdog and its frame errors. It picks one active lane and forwards
//   only whole frames from that lane to LLCRX. Lane changes happen only at
//   frame boundaries.
//
// Build option
//   SLINK_RX_REVERT_EN : when defined, the selector moves back to a
//                        lower-index alive lane while it sits between frames
//                        (revertive). When undefined, the active lane changes
//                        only when that lane dies.
//
// Ports
//   clk_125m, rst_125m   single clock; synchronous active-high reset
//   wd_timer             watchdog threshold in cycles (0 disables it)
//   ch_en                per-lane enable; 0 forces the lane dead
//   rx_dval/sop/eop/err  per-lane byte strobes; rx_err is valid with rx_eop
//   rx_data              lane i is at [i*DATA_W +: DATA_W]
//   out_*                forwarded stream, one cycle after rx_*
//   active_ch            index of the selected lane
//   ch_alive             per-lane health
//   all_dead             no lane is selected
//   switch_pulse         one-cycle pulse each time a lane is selected
//
// State  | Meaning
// IDLE   | no lane selected, waiting for any lane to become alive
// GAP    | lane selected, between frames; waiting for sop, may switch lanes
// FWD    | forwarding a frame from the active lane
module com_slink_rx_chsel #(
  parameter  int NUM_CH    = 2,
  parameter  int DATA_W    = 8,
  parameter  int WD_W      = 16,
  parameter  int RECOV_FRM = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_125m,
  input  logic                     rst_125m,
  input  logic [WD_W-1:0]          wd_timer,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        rx_dval,
  input  logic [NUM_CH-1:0]        rx_sop,
  input  logic [NUM_CH-1:0]        rx_eop,
  input  logic [NUM_CH-1:0]        rx_err,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic                     out_dval,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     out_err,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          active_ch,
  output logic [NUM_CH-1:0]        ch_alive,
  output logic                     all_dead,
  output logic                     switch_pulse
);

  localparam int              GC_W    = $clog2(RECOV_FRM + 1);
  localparam logic [GC_W-1:0] RECOV_C = GC_W'(RECOV_FRM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_FWD  = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Per-lane health
  // ---------------------------------------------------------------
  logic [NUM_CH-1:0][WD_W-1:0] r_wd_cnt;
  logic [NUM_CH-1:0][GC_W-1:0] r_good_cnt;
  logic [NUM_CH-1:0]           r_alive;

  logic [NUM_CH-1:0] w_good_eop;
  logic [NUM_CH-1:0] w_err_eop;
  logic [NUM_CH-1:0] w_wd_hit;

  always_comb begin
    w_good_eop = '0;
    w_err_eop  = '0;
    w_wd_hit   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_good_eop[i] = rx_dval[i] & rx_eop[i] & ~rx_err[i];
      w_err_eop[i]  = rx_dval[i] & rx_eop[i] &  rx_err[i];
      // compared one bit wider so a saturated counter never aliases the threshold
      w_wd_hit[i]   = (wd_timer != '0) &&
                      (({1'b0, r_wd_cnt[i]} + (WD_W+1)'(1)) == {1'b0, wd_timer});
    end
  end

  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      r_wd_cnt   <= '0;
      r_good_cnt <= '0;
      r_alive    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_en[i]) begin
          r_wd_cnt[i]   <= '0;
          r_good_cnt[i] <= '0;
          r_alive[i]    <= 1'b0;
        end else if (w_good_eop[i]) begin
          // a good eop beats a watchdog expiry landing in the same cycle
          r_wd_cnt[i] <= '0;
          if (r_good_cnt[i] != RECOV_C) begin
            r_good_cnt[i] <= r_good_cnt[i] + GC_W'(1);
            if ((r_good_cnt[i] + GC_W'(1)) == RECOV_C)
              r_alive[i] <= 1'b1;
          end else begin
            r_alive[i] <= 1'b1;
          end
        end else if (w_err_eop[i]) begin
          r_wd_cnt[i]   <= '0;
          r_good_cnt[i] <= '0;
          r_alive[i]    <= 1'b0;
        end else begin
          if (r_wd_cnt[i] != {WD_W{1'b1}})
            r_wd_cnt[i] <= r_wd_cnt[i] + WD_W'(1);
          if (w_wd_hit[i]) begin
            r_good_cnt[i] <= '0;
            r_alive[i]    <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Lane selection and forwarding
  // ---------------------------------------------------------------
  state_t            r_state;
  logic [CH_W-1:0]   r_active_ch;
  logic              r_switch;
  logic              r_out_dval;
  logic              r_out_sop;
  logic              r_out_eop;
  logic              r_out_err;
  logic [DATA_W-1:0] r_out_data;

  logic [DATA_W-1:0] w_lane_data [NUM_CH];
  logic [NUM_CH-1:0] w_usable;
  logic              w_any;
  logic [CH_W-1:0]   w_low;
  logic              w_act_ok;
  logic              w_act_dval;
  logic              w_act_sop;
  logic              w_act_eop;
  logic              w_act_err;
  logic [DATA_W-1:0] w_act_data;

  // A lane whose enable just dropped is treated as dead straight away,
  // so a frame in flight is closed one cycle after ch_en falls.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      w_lane_data[i] = rx_data[i*DATA_W +: DATA_W];
    w_usable = r_alive & ch_en;
    w_any    = |w_usable;
    w_low    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_usable[i]) w_low = CH_W'(i);
    w_act_ok   = w_usable[r_active_ch];
    w_act_dval = rx_dval[r_active_ch];
    w_act_sop  = rx_sop[r_active_ch];
    w_act_eop  = rx_eop[r_active_ch];
    w_act_err  = rx_err[r_active_ch];
    w_act_data = w_lane_data[r_active_ch];
  end

  always_ff @(posedge clk_125m) begin
    if (rst_125m) begin
      r_state     <= ST_IDLE;
      r_active_ch <= '0;
      r_switch    <= 1'b0;
      r_out_dval  <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_switch   <= 1'b0;
      r_out_dval <= 1'b0;
      r_out_sop  <= 1'b0;
      r_out_eop  <= 1'b0;
      r_out_err  <= 1'b0;
      r_out_data <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_active_ch <= w_low;
            r_switch    <= 1'b1;
            r_state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (!w_act_ok) begin
            if (w_any) begin
              r_active_ch <= w_low;
              r_switch    <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
`ifdef SLINK_RX_REVERT_EN
          else if (w_any && (w_low < r_active_ch)) begin
            r_active_ch <= w_low;
            r_switch    <= 1'b1;
          end
`endif
          else if (w_act_dval && w_act_sop) begin
            r_out_dval <= 1'b1;
            r_out_sop  <= 1'b1;
            r_out_data <= w_act_data;
            if (w_act_eop) begin
              r_out_eop <= 1'b1;
              r_out_err <= w_act_err;
            end else begin
              r_state <= ST_FWD;
            end
          end
          // bytes without sop belong to a frame we did not see start: dropped
        end
        ST_FWD: begin
          if (!w_act_ok || (w_act_dval && w_act_sop)) begin
            // truncate: close the frame with an errored empty eop;
            // a stray sop is swallowed and its frame is not joined
            r_out_dval <= 1'b1;
            r_out_eop  <= 1'b1;
            r_out_err  <= 1'b1;
            r_state    <= ST_GAP;
          end else if (w_act_dval) begin
            r_out_dval <= 1'b1;
            r_out_data <= w_act_data;
            if (w_act_eop) begin
              r_out_eop <= 1'b1;
              r_out_err <= w_act_err;
              r_state   <= ST_GAP;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_dval     = r_out_dval;
  assign out_sop      = r_out_sop;
  assign out_eop      = r_out_eop;
  assign out_err      = r_out_err;
  assign out_data     = r_out_data;
  assign active_ch    = r_active_ch;
  assign ch_alive     = r_alive;
  assign all_dead     = (r_state == ST_IDLE);
  assign switch_pulse = r_switch;

endmodule

// File: tb/tb_com_slink_rx_chsel.sv
// Directed bench for com_slink_rx_chsel, default (non-revertive) build,
// two lanes, 8-bit data, watchdog threshold 100, two good frames to recover.
module tb_com_slink_rx_chsel;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 8;
  localparam int WD_W   = 16;

  logic                     clk_125m = 1'b0;
  logic                     rst_125m;
  logic [WD_W-1:0]          wd_timer;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        rx_dval;
  logic [NUM_CH-1:0]        rx_sop;
  logic [NUM_CH-1:0]        rx_eop;
  logic [NUM_CH-1:0]        rx_err;
  logic [NUM_CH*DATA_W-1:0] rx_data;
  logic                     out_dval;
  logic                     out_sop;
  logic                     out_eop;
  logic                     out_err;
  logic [DATA_W-1:0]        out_data;
  logic                     active_ch;
  logic [NUM_CH-1:0]        ch_alive;
  logic                     all_dead;
  logic                     switch_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  always #4 clk_125m = ~clk_125m;

  com_slink_rx_chsel #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .WD_W(WD_W), .RECOV_FRM(2)
  ) dut (
    .clk_125m(clk_125m), .rst_125m(rst_125m), .wd_timer(wd_timer),
    .ch_en(ch_en), .rx_dval(rx_dval), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .rx_err(rx_err), .rx_data(rx_data),
    .out_dval(out_dval), .out_sop(out_sop), .out_eop(out_eop),
    .out_err(out_err), .out_data(out_data), .active_ch(active_ch),
    .ch_alive(ch_alive), .all_dead(all_dead), .switch_pulse(switch_pulse)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {dval, sop, eop, err, data}
  function automatic logic [31:0] outv();
    return 32'({out_dval, out_sop, out_eop, out_err, out_data});
  endfunction

  function automatic logic [31:0] mk(input logic v, input logic s, input logic e,
                                     input logic x, input logic [7:0] d);
    return 32'({v, s, e, x, d});
  endfunction

  task automatic step();
    @(posedge clk_125m);
    #1;
  endtask

  task automatic idle_rx();
    rx_dval = '0;
    rx_sop  = '0;
    rx_eop  = '0;
    rx_err  = '0;
    rx_data = '0;
  endtask

  task automatic put(input int lane, input logic [7:0] d, input logic s,
                     input logic e, input logic x);
    rx_dval[lane] = 1'b1;
    rx_sop[lane]  = s;
    rx_eop[lane]  = e;
    rx_err[lane]  = x;
    rx_data[lane*DATA_W +: DATA_W] = d;
  endtask

  task automatic byte1(input int lane, input logic [7:0] d, input logic s,
                       input logic e, input logic x);
    put(lane, d, s, e, x);
    step();
    idle_rx();
  endtask

  initial begin
    rst_125m = 1'b1;
    wd_timer = 16'd100;
    ch_en    = 2'b11;
    idle_rx();
    repeat (3) step();

    // reset state
    check_val("rst_all_dead", 32'(all_dead), 32'(1));
    check_val("rst_out", outv(), 32'(0));
    check_val("rst_sel", 32'({active_ch, switch_pulse}), 32'(0));
    check_val("rst_alive", 32'(ch_alive), 32'(0));
    rst_125m = 1'b0;

    // T1: two good frames bring lane0 alive, then it is selected
    for (int f = 0; f < 2; f++) begin
      byte1(0, 8'h10, 1'b1, 1'b0, 1'b0);
      byte1(0, 8'h11, 1'b0, 1'b0, 1'b0);
      byte1(0, 8'h12, 1'b0, 1'b1, 1'b0);
    end
    check_val("t1_alive", 32'(ch_alive), 32'(2'b01));
    check_val("t1_no_fwd_idle", 32'(out_dval), 32'(0));
    check_val("t1_dead_before", 32'(all_dead), 32'(1));
    step();
    check_val("t1_sel", 32'({all_dead, switch_pulse, active_ch}), 32'(3'b010));
    step();
    check_val("t1_pulse_once", 32'(switch_pulse), 32'(0));

    // T2: 5-byte frame AA..AE on lane0
    for (int i = 0; i < 5; i++) begin
      byte1(0, 8'(8'hAA + i), (i == 0), (i == 4), 1'b0);
      check_val($sformatf("t2_b%0d", i), outv(),
                mk(1'b1, (i == 0), (i == 4), 1'b0, 8'(8'hAA + i)));
    end
    step();
    check_val("t2_idle", outv(), 32'(0));
    byte1(0, 8'h33, 1'b0, 1'b0, 1'b0);
    check_val("gap_drop", 32'(out_dval), 32'(0));

    // T3: lane1 alive, lane0 refreshed then silent until its watchdog expires
    byte1(1, 8'h40, 1'b1, 1'b1, 1'b0);
    check_val("t3_l1_drop", 32'(out_dval), 32'(0));
    byte1(1, 8'h41, 1'b1, 1'b1, 1'b0);
    check_val("t3_both_alive", 32'(ch_alive), 32'(2'b11));
    byte1(0, 8'h5A, 1'b1, 1'b1, 1'b0);
    check_val("t3_single", outv(), mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h5A));
    for (int k = 1; k <= 99; k++) begin
      if (k == 50) put(1, 8'h42, 1'b1, 1'b1, 1'b0);
      step();
      idle_rx();
    end
    check_val("t3_alive_pre", 32'(ch_alive), 32'(2'b11));
    step();
    check_val("t3_timeout", 32'(ch_alive), 32'(2'b10));
    step();
    check_val("t3_switch", 32'({active_ch, switch_pulse}), 32'(2'b11));

    // T5: lane0 recovers while lane1 is active; non-revertive keeps lane1
    byte1(0, 8'h60, 1'b1, 1'b1, 1'b0);
    byte1(0, 8'h61, 1'b1, 1'b1, 1'b0);
    check_val("t5_recov", 32'(ch_alive), 32'(2'b11));
    for (int j = 0; j < 3; j++) begin
      step();
      check_val($sformatf("t5_stay%0d", j), 32'({active_ch, switch_pulse}), 32'(2'b10));
    end

    // errored frame on the active lane kills it; fail-over to lane0
    byte1(1, 8'h51, 1'b1, 1'b0, 1'b0);
    check_val("err_sop", outv(), mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h51));
    byte1(1, 8'h52, 1'b0, 1'b1, 1'b1);
    check_val("err_eop", outv(), mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h52));
    check_val("err_kill", 32'(ch_alive), 32'(2'b01));
    step();
    check_val("err_switch", 32'({active_ch, switch_pulse}), 32'(2'b01));

    // T4: lane0 disabled mid-frame after 3 bytes
    byte1(1, 8'h43, 1'b1, 1'b1, 1'b0);
    byte1(1, 8'h44, 1'b1, 1'b1, 1'b0);
    check_val("t4_l1_alive", 32'(ch_alive), 32'(2'b11));
    byte1(0, 8'hC0, 1'b1, 1'b0, 1'b0);
    byte1(0, 8'hC1, 1'b0, 1'b0, 1'b0);
    byte1(0, 8'hC2, 1'b0, 1'b0, 1'b0);
    check_val("t4_b2", outv(), mk(1'b1, 1'b0, 1'b0, 1'b0, 8'hC2));
    ch_en = 2'b10;
    step();
    check_val("t4_abort", outv(), mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h00));
    check_val("t4_dead", 32'(ch_alive), 32'(2'b10));
    step();
    check_val("t4_switch", 32'({active_ch, switch_pulse}), 32'(2'b11));
    byte1(0, 8'hC3, 1'b1, 1'b0, 1'b0);
    check_val("t4_l0_drop", 32'(out_dval), 32'(0));

    // stray sop inside a frame truncates it and is not forwarded
    byte1(1, 8'h71, 1'b1, 1'b0, 1'b0);
    check_val("st_sop", outv(), mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h71));
    byte1(1, 8'h72, 1'b0, 1'b0, 1'b0);
    byte1(1, 8'h73, 1'b1, 1'b0, 1'b0);
    check_val("st_abort", outv(), mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h00));
    byte1(1, 8'h74, 1'b0, 1'b1, 1'b0);
    check_val("st_drop", 32'(out_dval), 32'(0));

    // T6: reset during FWD, then eop/watchdog collision
    ch_en = 2'b11;
    byte1(1, 8'h61, 1'b1, 1'b0, 1'b0);
    check_val("t6_fwd", outv(), mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h61));
    rst_125m = 1'b1;
    put(1, 8'h62, 1'b0, 1'b0, 1'b0);
    step();
    idle_rx();
    check_val("t6_rst_out", outv(), 32'(0));
    check_val("t6_rst_state", 32'({all_dead, active_ch, ch_alive, switch_pulse}), 32'(5'b10000));
    rst_125m = 1'b0;
    byte1(1, 8'h63, 1'b0, 1'b1, 1'b0);
    check_val("t6_no_eop", outv(), 32'(0));
    byte1(0, 8'h80, 1'b1, 1'b1, 1'b0);
    byte1(0, 8'h81, 1'b1, 1'b1, 1'b0);
    check_val("t6_alive", 32'(ch_alive), 32'(2'b01));
    repeat (99) step();
    check_val("t6_pre", 32'(ch_alive), 32'(2'b01));
    byte1(0, 8'h90, 1'b1, 1'b1, 1'b0);
    check_val("t6_collide", 32'(ch_alive), 32'(2'b01));
    check_val("t6_col_fwd", outv(), mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h90));
    repeat (99) step();
    check_val("t6_hold", 32'(ch_alive), 32'(2'b01));
    step();
    check_val("t6_expire", 32'(ch_alive), 32'(2'b00));
    step();
    check_val("t6_all_dead", 32'(all_dead), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
